// File: rtl/aoi21_bist_pkg.sv
// Shared definitions for the AOI21 built-in self-test: FSM states, the golden
// truth table and the settle counter width.
package aoi21_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit idx holds ~((A&B)|C) for {A,B,C} = idx.
  localparam logic [7:0] EXP_TABLE = 8'h15;

  localparam int unsigned CNT_W   = 4;
  localparam logic [3:0]  ERR_MAX = 4'd8;

endpackage

// File: rtl/aoi21_ref_model.sv
// Combinational golden model of the AOI21 cell: expected Y for a pattern index.
module aoi21_ref_model
  import aoi21_bist_pkg::*;
(
  input  logic [2:0] i_idx,
  output logic       o_y_exp
);

  assign o_y_exp = EXP_TABLE[i_idx];

endmodule

// File: rtl/aoi21_bist.sv
// Exhaustive 8-pattern self-test of an AOI21 cell: drives A/B/C, lets the cell
// settle, samples Y_IN and records per-pattern mismatches.
module aoi21_bist
  import aoi21_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       START,
  input  logic       ABORT,
  input  logic       Y_IN,
  output logic       A_OUT,
  output logic       B_OUT,
  output logic       C_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [7:0] FAIL_VEC
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_e           r_state,    w_state_nxt;
  logic [2:0]       r_idx,      w_idx_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [3:0]       r_err_cnt,  w_err_nxt;
  logic [7:0]       r_fail_vec, w_fail_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_done,     w_done_nxt;
  logic             r_pass,     w_pass_nxt;
  logic             w_y_exp;

  aoi21_ref_model u_ref (
    .i_idx   (r_idx),
    .o_y_exp (w_y_exp)
  );

  // NOTE: every signal is given a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err_cnt;
    w_fail_nxt  = r_fail_vec;

    if (ABORT) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_err_nxt   = '0;
      w_fail_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            w_state_nxt = ST_SETTLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_err_nxt   = '0;
            w_fail_nxt  = '0;
          end
        end
        ST_SETTLE: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (Y_IN != w_y_exp) begin
            if (r_err_cnt != ERR_MAX) w_err_nxt = r_err_cnt + 1'b1;
            w_fail_nxt = r_fail_vec | (8'd1 << r_idx);
          end
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = ST_SETTLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Status flags are computed from the next state so they can be registered
    // and still line up with the state they describe.
    w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
    w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_err_cnt  <= '0;
      r_fail_vec <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err_cnt  <= w_err_nxt;
      r_fail_vec <= w_fail_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
    end
  end

  assign {A_OUT, B_OUT, C_OUT} = r_idx;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign PASS     = r_pass;
  assign ERR_CNT  = r_err_cnt;
  assign FAIL_VEC = r_fail_vec;

endmodule

// File: tb/tb_aoi21_bist.sv
// Self-checking bench for aoi21_bist: a behavioural AOI21 cell (good, stuck or
// with random faulty patterns) drives Y_IN; results are predicted per sweep.
module tb_aoi21_bist;

  localparam int S         = 2;
  localparam int SWEEP_LEN = 8 * (S + 1);
  localparam int BOUND     = 200;

  logic       clk, rst_n, start, abort, y_in;
  logic       a_out, b_out, c_out, busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_vec;
  logic [2:0] stim;

  int         mode;       // 0: good cell xor flip_mask, 1: stuck at 0, 2: stuck at 1
  logic [7:0] flip_mask;
  int         n_cmp = 0;
  int         n_bad = 0;

  aoi21_bist #(.SETTLE_CYC(S)) dut (
    .CLK      (clk),
    .R        (rst_n),
    .START    (start),
    .ABORT    (abort),
    .Y_IN     (y_in),
    .A_OUT    (a_out),
    .B_OUT    (b_out),
    .C_OUT    (c_out),
    .BUSY     (busy),
    .DONE     (done),
    .PASS     (pass),
    .ERR_CNT  (err_cnt),
    .FAIL_VEC (fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign stim = {a_out, b_out, c_out};

  function automatic logic golden(input logic [2:0] p);
    return !((p[2] && p[1]) || p[0]);
  endfunction

  function automatic logic cut_resp(input logic [2:0] p, input int m, input logic [7:0] fm);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return golden(p) ^ fm[p];
  endfunction

  assign y_in = cut_resp(stim, mode, flip_mask);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_outs"}, {busy, done, pass, err_cnt, fail_vec, stim}, '0);
  endtask

  // Expected results of a complete sweep for the current cell model.
  task automatic predict(output int exp_err, output logic [7:0] exp_fail);
    exp_err  = 0;
    exp_fail = '0;
    for (int p = 0; p < 8; p++) begin
      if (cut_resp(3'(p), mode, flip_mask) != golden(3'(p))) begin
        exp_err++;
        exp_fail[p] = 1'b1;
      end
    end
  endtask

  // Pulses START (held for `hold` extra edges), tracks the sweep edge by edge.
  // stop_at > 0 returns after that many edges, leaving the sweep in progress.
  task automatic run_sweep(input int hold, input int stop_at);
    int         exp_err;
    logic [7:0] exp_fail;
    int         n;
    predict(exp_err, exp_fail);
    start = 1'b1;
    @(posedge clk); #1;
    if (hold == 0) start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("done_after_start", done, 1'b0);
    for (n = 1; n <= BOUND; n++) begin
      @(posedge clk); #1;
      if (n >= hold) start = 1'b0;
      if (done) break;
      if (n < SWEEP_LEN) begin
        check("busy", busy, 1'b1);
        check("stim", stim, n / (S + 1));
      end
      if (stop_at > 0 && n == stop_at) return;
    end
    start = 1'b0;
    check("done_edge", n, SWEEP_LEN);
    check("done_busy", {done, busy}, 2'b10);
    check("err_cnt", err_cnt, exp_err);
    check("fail_vec", fail_vec, exp_fail);
    check("pass", pass, exp_err == 0);
    check("stim_done", stim, 3'd7);
    repeat (3) @(posedge clk);
    #1;
    check("held", {done, pass, err_cnt, fail_vec}, {1'b1, exp_err == 0, 4'(exp_err), exp_fail});
  endtask

  initial begin
    int         exp_err;
    logic [7:0] exp_fail;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    mode      = 0;
    flip_mask = '0;

    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_idle("post_reset");

    // Good cell, START held high into BUSY.
    run_sweep($urandom_range(1, 20), 0);

    mode = 1;
    run_sweep(0, 0);
    check("stuck0_err", err_cnt, 4'd3);
    check("stuck0_vec", fail_vec, 8'h15);

    // Restart directly from DONE with a good cell.
    mode = 0;
    run_sweep(0, 0);
    check("restart_pass", pass, 1'b1);

    mode = 2;
    run_sweep(0, 0);
    check("stuck1_err", err_cnt, 4'd5);
    check("stuck1_vec", fail_vec, 8'hEA);

    // Abort during pattern 4, START asserted in the same cycle.
    mode = 1;
    run_sweep(0, 4 * (S + 1) + 1);
    check("pre_abort_idx", stim, 3'd4);
    check("pre_abort_err", err_cnt, 4'd2);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check_idle("abort");
    repeat (2) @(posedge clk);
    #1 check_idle("abort_hold");

    // Asynchronous reset during pattern 5, then a fresh sweep.
    mode = 0;
    run_sweep(0, 5 * (S + 1) + 1);
    rst_n = 1'b0;
    #2 check_idle("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle("needs_start");
    run_sweep(0, 0);

    // Random faulty-pattern sets.
    for (int k = 0; k < 6; k++) begin
      mode      = 0;
      flip_mask = 8'($urandom);
      run_sweep($urandom_range(0, 15), 0);
    end
    flip_mask = 8'hFF;
    run_sweep(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aoi21_bist.md
AOI21_BIST -- requirements
Module: aoi21_bist

Interface
REQ-001 SHALL have parameter: SETTLE_CYC, default 2, cycles the cell under test (CUT) is given to settle per pattern (legal 1..15).
REQ-002 SHALL have port: CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: R  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: START  input  1  begin sweep (sampled; level, acted on only in IDLE or DONE).
REQ-005 SHALL have port: ABORT  input  1  terminate sweep, return to IDLE.
REQ-006 SHALL have port: Y_IN  input  1  CUT output, same clock domain, sampled in SAMPLE only.
REQ-007 SHALL have ports: A_OUT, B_OUT, C_OUT  output  1 each  stimulus to CUT inputs A, B, C (registered).
REQ-008 SHALL have port: BUSY  output  1  high in SETTLE and SAMPLE.
REQ-009 SHALL have port: DONE  output  1  high while in DONE state.
REQ-010 SHALL have port: PASS  output  1  high in DONE iff ERR_CNT==0; low otherwise.
REQ-011 SHALL have port: ERR_CNT  output  4  count of mismatching patterns, range 0..8.
REQ-012 SHALL have port: FAIL_VEC  output  8  bit i set iff pattern i mismatched.

Function
REQ-013 SHALL step pattern index idx 0..7 with {A_OUT,B_OUT,C_OUT} = idx[2:0].
REQ-014 SHALL compute expected Y = ~((A&B)|C); equivalently expected bit idx of constant 8'h15.
REQ-015 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE: START=1 -> SETTLE; idx, settle counter, ERR_CNT and FAIL_VEC cleared; stimulus = pattern 0.
REQ-017 SETTLE: counter increments each cycle; at count SETTLE_CYC-1 -> SAMPLE.
REQ-018 SAMPLE: compare Y_IN to expected; on mismatch ERR_CNT+1 and FAIL_VEC[idx] set, in the same edge.
REQ-019 SAMPLE with idx<7: idx+1, stimulus updated, counter cleared -> SETTLE; idx==7 -> DONE.
REQ-020 Each pattern SHALL take exactly SETTLE_CYC+1 cycles; DONE SHALL assert exactly 8*(SETTLE_CYC+1) rising edges after the edge capturing START.
REQ-021 DONE: results held, stimulus held at pattern 7; START=1 -> SETTLE with results cleared, as from IDLE.
REQ-022 START while BUSY SHALL be ignored.
REQ-023 ABORT=1 in any state -> IDLE next edge; stimulus to 0, ERR_CNT and FAIL_VEC cleared, DONE/PASS low.
REQ-024 ABORT and START in the same cycle: ABORT SHALL win.
REQ-025 ERR_CNT SHALL not wrap; 4 bits hold the maximum of 8.

Reset
REQ-026 R low SHALL force IDLE asynchronously, including mid-sweep.
REQ-027 R low SHALL clear all outputs to 0, including PASS, and all internal counters.
REQ-028 The first sweep after R deassertion SHALL require a fresh START.

Structure
REQ-029 SHALL place in shared package aoi21_bist_pkg:
  - FSM state enum
  - expected truth-table constant 8'h15
  - settle counter width 4
REQ-030 SHALL use one sub-module aoi21_ref_model: a combinational golden model giving expected Y from idx.
REQ-031 SHALL keep all outputs registered, with no combinational path from Y_IN to any output.

Verification
REQ-032 Correct AOI21 model on Y_IN, SETTLE_CYC=2, START pulse -> DONE after 24 edges, PASS=1, ERR_CNT=0, FAIL_VEC=8'h00.
REQ-033 Y_IN stuck at 0 -> ERR_CNT=3, FAIL_VEC=8'h15, PASS=0.
REQ-034 Y_IN stuck at 1 -> ERR_CNT=5, FAIL_VEC=8'hEA, PASS=0.
REQ-035 ABORT during pattern 4 -> IDLE next edge, all outputs 0; START held high during BUSY has no effect (count stays 24).
REQ-036 R low during pattern 5, then release and START -> fresh sweep with results identical to REQ-032.
REQ-037 START in DONE after REQ-033 with good model -> results cleared; PASS=1 after 24 edges.
